// File: rtl/mulfx_pkg.sv
// Shared types and helpers for the sequential fixed-point multiplier:
// FSM state encoding, iteration count and saturation limits.
package mulfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Wide enough to hold any clamp limit for operands up to 64 bits.
    localparam int SAT_W = 130;

    function automatic int iters(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_max(input int width, input logic sgn);
        logic signed [SAT_W-1:0] one_v;
        one_v = {{(SAT_W-1){1'b0}}, 1'b1};
        if (sgn) begin
            sat_max = (one_v << (width - 1)) - one_v;
        end else begin
            sat_max = (one_v << width) - one_v;
        end
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int width, input logic sgn);
        logic signed [SAT_W-1:0] one_v;
        one_v = {{(SAT_W-1){1'b0}}, 1'b1};
        if (sgn) begin
            sat_min = -(one_v << (width - 1));
        end else begin
            sat_min = {SAT_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/mulfx_scale.sv
// Combinational post-processing of the full product: optional round-half-up,
// FRAC_BITS right shift (arithmetic when signed) and clamp to WIDTH bits.
module mulfx_scale
    import mulfx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int FRAC_BITS = 0
) (
    input  logic [2*WIDTH-1:0] product,
    input  logic               sgn,
    input  logic               rnd,
    output logic [WIDTH-1:0]   result,
    output logic               ovf
);

    localparam int TW = 2*WIDTH + 1;
    localparam logic signed [TW-1:0] BIAS = TW'((1 << FRAC_BITS) >> 1);

    logic signed [TW-1:0]    ext_s;
    logic signed [TW-1:0]    bias_s;
    logic signed [TW-1:0]    t_s;
    logic signed [TW-1:0]    sh_s;
    logic signed [SAT_W-1:0] sh_wide_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;

    // Extend, bias, shift, then compare against the clamp window.
    always_comb begin
        ext_s     = sgn ? {product[2*WIDTH-1], product} : {1'b0, product};
        bias_s    = rnd ? BIAS : {TW{1'b0}};
        t_s       = ext_s + bias_s;
        sh_s      = t_s >>> FRAC_BITS;
        sh_wide_s = {{(SAT_W-TW){sh_s[TW-1]}}, sh_s};
        max_s     = sat_max(WIDTH, sgn);
        min_s     = sat_min(WIDTH, sgn);
        result    = sh_s[WIDTH-1:0];
        ovf       = 1'b0;
        if (sh_wide_s > max_s) begin
            result = max_s[WIDTH-1:0];
            ovf    = 1'b1;
        end else if (sh_wide_s < min_s) begin
            result = min_s[WIDTH-1:0];
            ovf    = 1'b1;
        end else begin
            result = sh_s[WIDTH-1:0];
            ovf    = 1'b0;
        end
    end

endmodule

// File: rtl/mulfx_seq_core.sv
// Sequential shift-and-add fixed-point multiplier with valid/ready on both sides.
// Define MULFX_SIGNED_EN to honour in_signed (magnitude multiply + negate, signed clamp).
module mulfx_seq_core
    import mulfx_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1,
    parameter int FRAC_BITS      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_round,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int ITERS = iters(WIDTH, BITS_PER_CYCLE);
    localparam int CW    = $clog2(ITERS + 1);

    state_t             state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r, mcand_r, pp_s, acc_nxt_s, prod_s;
    logic [WIDTH-1:0]   mult_r, a_mag_s, b_mag_s;
    logic               neg_r, sgn_r, rnd_r;
    logic               sgn_eff_s, neg_in_s;
    logic               accept_s, last_s;
    logic [WIDTH-1:0]   res_s;
    logic               ovf_s;
    logic               out_valid_r, out_ovf_r, busy_r;
    logic [2*WIDTH-1:0] out_product_r;
    logic [WIDTH-1:0]   out_result_r;

    assign in_ready = rst_n & ((state_r == IDLE) | ((state_r == HOLD) & out_ready));
    assign accept_s = in_valid & in_ready;
    assign last_s   = (state_r == RUN) && (cnt_r == CW'(1));

`ifdef MULFX_SIGNED_EN
    // Operand magnitudes and result sign; |-2^(WIDTH-1)| still fits WIDTH unsigned bits.
    always_comb begin
        sgn_eff_s = in_signed;
        a_mag_s   = (in_signed && in_a[WIDTH-1]) ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
        b_mag_s   = (in_signed && in_b[WIDTH-1]) ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;
        neg_in_s  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end
    assign prod_s = neg_r ? (~acc_nxt_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_nxt_s;
`else
    logic sgn_unused_s;
    assign sgn_eff_s    = 1'b0;
    assign a_mag_s      = in_a;
    assign b_mag_s      = in_b;
    assign neg_in_s     = 1'b0;
    assign prod_s       = acc_nxt_s;
    assign sgn_unused_s = in_signed | neg_r;
`endif

    // Partial product for the multiplier digit retired this cycle.
    always_comb begin
        pp_s = {(2*WIDTH){1'b0}};
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            pp_s = pp_s + ((mcand_r << i) & {(2*WIDTH){mult_r[i]}});
        end
        acc_nxt_s = acc_r + pp_s;
    end

    mulfx_scale #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_scale (
        .product (prod_s),
        .sgn     (sgn_r),
        .rnd     (rnd_r),
        .result  (res_s),
        .ovf     (ovf_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = HOLD;
                else        state_nxt_s = RUN;
            end
            HOLD: begin
                if (out_ready) state_nxt_s = accept_s ? RUN : IDLE;
                else           state_nxt_s = HOLD;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture and shift-and-add iteration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {(2*WIDTH){1'b0}};
            mult_r  <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            sgn_r   <= 1'b0;
            rnd_r   <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= CW'(ITERS);
            acc_r   <= {(2*WIDTH){1'b0}};
            mcand_r <= {{WIDTH{1'b0}}, a_mag_s};
            mult_r  <= b_mag_s;
            neg_r   <= neg_in_s;
            sgn_r   <= sgn_eff_s;
            rnd_r   <= in_round;
        end else if (state_r == RUN) begin
            cnt_r   <= cnt_r - CW'(1);
            acc_r   <= acc_nxt_s;
            mcand_r <= mcand_r << BITS_PER_CYCLE;
            mult_r  <= mult_r >> BITS_PER_CYCLE;
        end
    end

    // Result registers: loaded on the last iteration, held until the consumer takes them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*WIDTH){1'b0}};
            out_result_r  <= {WIDTH{1'b0}};
            out_ovf_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == RUN);
            if (last_s) begin
                out_valid_r   <= 1'b1;
                out_product_r <= prod_s;
                out_result_r  <= res_s;
                out_ovf_r     <= ovf_s;
            end else if ((state_r == HOLD) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign out_product = out_product_r;
    assign out_result  = out_result_r;
    assign out_ovf     = out_ovf_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mulfx_seq_core.sv
// Scoreboard bench for mulfx_seq_core: dut a (BPC=1, FRAC=0) and dut b (BPC=2, FRAC=4).
module tb_mulfx_seq_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_in_signed, a_in_round;
    logic        a_out_valid, a_out_ready, a_out_ovf, a_busy;
    logic [7:0]  a_in_a, a_in_b, a_out_result;
    logic [15:0] a_out_product;
    logic        b_in_valid, b_in_ready, b_in_signed, b_in_round;
    logic        b_out_valid, b_out_ready, b_out_ovf, b_busy;
    logic [7:0]  b_in_a, b_in_b, b_out_result;
    logic [15:0] b_out_product;

    typedef struct packed {
        logic [15:0] prod;
        logic [7:0]  res;
        logic        ovf;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mulfx_seq_core #(.WIDTH(8), .BITS_PER_CYCLE(1), .FRAC_BITS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_signed(a_in_signed), .in_round(a_in_round),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_product(a_out_product),
        .out_result(a_out_result), .out_ovf(a_out_ovf), .busy(a_busy)
    );

    mulfx_seq_core #(.WIDTH(8), .BITS_PER_CYCLE(2), .FRAC_BITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_signed(b_in_signed), .in_round(b_in_round),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_product(b_out_product),
        .out_result(b_out_result), .out_ovf(b_out_ovf), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for dut a: compare every completed output handshake with the queue head.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected_result", 32'(a_out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_a_q.pop_front();
                chk("a_product", 32'(a_out_product), 32'(e.prod));
                chk("a_result",  32'(a_out_result),  32'(e.res));
                chk("a_ovf",     32'(a_out_ovf),     32'(e.ovf));
            end
        end
    end

    // Monitor for dut b.
    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (exp_b_q.size() == 0) begin
                chk("b_unexpected_result", 32'(b_out_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_b_q.pop_front();
                chk("b_product", 32'(b_out_product), 32'(e.prod));
                chk("b_result",  32'(b_out_result),  32'(e.res));
                chk("b_ovf",     32'(b_out_ovf),     32'(e.ovf));
            end
        end
    end

    // Issue one operation (called just after a posedge) and wait for its result.
    task automatic op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                      input logic sg, input logic rn,
                      input logic [15:0] ep, input logic [7:0] er, input logic eo);
        exp_t e;
        int   n;
        e = '{prod: ep, res: er, ovf: eo};
        if (sel) begin
            b_in_a = a; b_in_b = b; b_in_signed = sg; b_in_round = rn; b_in_valid = 1'b1;
            exp_b_q.push_back(e);
        end else begin
            a_in_a = a; a_in_b = b; a_in_signed = sg; a_in_round = rn; a_in_valid = 1'b1;
            exp_a_q.push_back(e);
        end
        @(negedge clk);
        chk(sel ? "b_in_ready_accept" : "a_in_ready_accept",
            32'(sel ? b_in_ready : a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        chk(sel ? "b_busy_run" : "a_busy_run", 32'(sel ? b_busy : a_busy), 32'd1);
        n = 0;
        while (!(sel ? b_out_valid : a_out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(sel ? "b_latency" : "a_latency", 32'(n), sel ? 32'd4 : 32'd8);
        chk(sel ? "b_busy_hold" : "a_busy_hold", 32'(sel ? b_busy : a_busy), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_a = 8'h00; a_in_b = 8'h00; a_in_signed = 1'b0; a_in_round = 1'b0;
        b_in_valid = 1'b0; b_in_a = 8'h00; b_in_b = 8'h00; b_in_signed = 1'b0; b_in_round = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_in_ready",  32'(a_in_ready),    32'd0);
        chk("rst_a_out_valid", 32'(a_out_valid),   32'd0);
        chk("rst_a_busy",      32'(a_busy),        32'd0);
        chk("rst_a_ovf",       32'(a_out_ovf),     32'd0);
        chk("rst_a_product",   32'(a_out_product), 32'd0);
        chk("rst_a_result",    32'(a_out_result),  32'd0);
        chk("rst_b_in_ready",  32'(b_in_ready),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // dut a: unsigned, no scaling
        op(1'b0, 8'd13,  8'd11,  1'b0, 1'b0, 16'h008F, 8'h8F, 1'b0);
        op(1'b0, 8'd255, 8'd255, 1'b0, 1'b0, 16'hFE01, 8'hFF, 1'b1);
        op(1'b0, 8'd0,   8'd200, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        op(1'b0, 8'd16,  8'd15,  1'b0, 1'b0, 16'h00F0, 8'hF0, 1'b0);
        op(1'b0, 8'd16,  8'd16,  1'b0, 1'b0, 16'h0100, 8'hFF, 1'b1);
        op(1'b0, 8'd13,  8'd11,  1'b0, 1'b1, 16'h008F, 8'h8F, 1'b0);
`ifdef MULFX_SIGNED_EN
        op(1'b0, 8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 8'hF1, 1'b0);
        op(1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 8'h7F, 1'b1);
        op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 16'hFF80, 8'h80, 1'b0);
`else
        op(1'b0, 8'hFD, 8'h05, 1'b1, 1'b0, 16'h04F1, 8'hFF, 1'b1);
        op(1'b0, 8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 8'hFF, 1'b1);
        op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0, 16'h0080, 8'h80, 1'b0);
`endif

        // dut b: FRAC_BITS=4, two bits per cycle
        op(1'b1, 8'h19, 8'h19, 1'b0, 1'b1, 16'h0271, 8'h27, 1'b0);
        op(1'b1, 8'h19, 8'h19, 1'b0, 1'b0, 16'h0271, 8'h27, 1'b0);
        op(1'b1, 8'h18, 8'h01, 1'b0, 1'b1, 16'h0018, 8'h02, 1'b0);
        op(1'b1, 8'h18, 8'h01, 1'b0, 1'b0, 16'h0018, 8'h01, 1'b0);
        op(1'b1, 8'h10, 8'hFF, 1'b0, 1'b0, 16'h0FF0, 8'hFF, 1'b0);
        op(1'b1, 8'h11, 8'hF1, 1'b0, 1'b0, 16'h1001, 8'hFF, 1'b1);
        op(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 8'hFF, 1'b1);

        // dut b: backpressure then back-to-back acceptance
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        op(1'b1, 8'h18, 8'h18, 1'b0, 1'b0, 16'h0240, 8'h24, 1'b0);
        b_in_a = 8'h19; b_in_b = 8'h19; b_in_signed = 1'b0; b_in_round = 1'b1; b_in_valid = 1'b1;
        exp_b_q.push_back('{prod: 16'h0271, res: 8'h27, ovf: 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(b_out_valid),   32'd1);
            chk("bp_product",   32'(b_out_product), 32'h0240);
            chk("bp_result",    32'(b_out_result),  32'h24);
            chk("bp_in_ready",  32'(b_in_ready),    32'd0);
            @(posedge clk); #1;
        end
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_round = 1'b0;
        b_in_a = 8'hFF;
        chk("b2b_valid_cleared", 32'(b_out_valid), 32'd0);
        chk("b2b_busy", 32'(b_busy), 32'd1);
        n = 0;
        while (!b_out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_latency", 32'(n), 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // dut a: reset in the third RUN cycle discards the operation
        a_in_a = 8'd13; a_in_b = 8'd11; a_in_signed = 1'b0; a_in_round = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready_low", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_out_valid", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready_after", 32'(a_in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (a_out_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_product_cleared", 32'(a_out_product), 32'd0);
        op(1'b0, 8'd13, 8'd11, 1'b0, 1'b0, 16'h008F, 8'h8F, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        chk("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
        chk("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mulfx_seq_core.md
# mulfx_seq_core

Parametrised sequential shift-and-add fixed-point multiplier. It generalises the 8x8 tile core to WIDTH-bit operands, configurable radix (bits retired per cycle), an optional signed mode, round-to-nearest scaling and saturation. It uses a valid/ready handshake on both sides. It sits between the tile's operand registers and the output byte mux, and is reusable by any block that needs a small-area multiplier.

## Interface
- WIDTH, 8, operand width in bits; ≥2.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; must divide WIDTH (1, 2 or 4 typical).
- FRAC_BITS, 0, right shift applied to the product for `out_result`; 0..WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  core can accept operands this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  treat operands as two's complement (effective only with the signed macro).
- in_round  in  1  round-half-up before the FRAC_BITS shift.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- out_product  out  2*WIDTH  full unscaled product.
- out_result  out  WIDTH  scaled, rounded, saturated result.
- out_ovf  out  1  `out_result` was saturated.
- busy  out  1  high in RUN.

## Operation
- N = WIDTH/BITS_PER_CYCLE iterations.
- FSM has three states:
  - IDLE: in_ready=1. When in_valid, capture operands, go to RUN, load counter=N.
  - RUN: each cycle do acc += mcand * mult[BITS_PER_CYCLE-1:0], then mcand <<= BITS_PER_CYCLE and mult >>= BITS_PER_CYCLE. Decrement the counter. On the last iteration, register the outputs, set out_valid and go to HOLD.
  - HOLD: outputs stable. If out_ready and not in_valid, clear out_valid and go to IDLE. If out_ready and in_valid, accept the new operands, clear out_valid and go to RUN (back-to-back).
- in_ready = rst_n & ((state==IDLE) | (state==HOLD & out_ready)).
- A handshake fires only when in_valid & in_ready. Operands not accepted are ignored.
- Signed mode:
  - Multiply the magnitudes. |−2^(WIDTH−1)| fits WIDTH unsigned bits.
  - Result sign = a_msb ^ b_msb.
  - Conditionally negate the 2*WIDTH product when registering the output.
- Scaling:
  - t = product (sign-extended to 2*WIDTH+1 bits) + (in_round && FRAC_BITS>0 ? 2^(FRAC_BITS−1) : 0).
  - Arithmetic shift right by FRAC_BITS (logical when unsigned).
- Saturation:
  - Unsigned: clamp to [0, 2^WIDTH−1].
  - Signed: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - out_ovf=1 iff clamping occurred.
- in_signed and in_round are captured with the operands. Changes after acceptance have no effect.

## Timing
- Reset values: state=IDLE; out_valid, busy, out_ovf = 0; out_product and out_result = 0. in_ready is 0 while rst_n is low.
- Latency: accept at edge k → out_valid high after edge k+N. With WIDTH=8 and BITS_PER_CYCLE=1 that is 8 cycles.
- Throughput: one result every N+1 cycles with continuous out_ready.
- out_valid stays high and all out_* stay constant until out_ready is sampled high. There is no drop and no overwrite.
- Reset mid-RUN or mid-HOLD: the result is discarded, all state returns to reset values, and no out_valid is produced.
- in_valid held during RUN is not accepted. It is accepted in HOLD together with out_ready, or in IDLE.

## Configuration
- MULFX_SIGNED_EN defined: in_signed is honoured and the signed magnitude/negate path and signed clamp limits are built.
- MULFX_SIGNED_EN not defined:
  - in_signed is ignored (treated as 0), so all operations are unsigned.
  - The negate logic is absent.
  - The port remains for interface stability.

## Structure
- Package mulfx_pkg holds:
  - the FSM state enum (IDLE, RUN, HOLD);
  - functions giving the saturation max/min for a width and signedness;
  - a localparam helper for ITERS = WIDTH/BITS_PER_CYCLE.
- Sub-module mulfx_scale: combinational round, shift and saturate. Inputs are product, signed and round. Outputs are result and ovf. It is parametrised by WIDTH and FRAC_BITS and instantiated once ahead of the output registers.

## Test plan
- WIDTH=8, BPC=1, unsigned: 13×11 → after 8 cycles, out_product=0x008F, out_result=0x8F, out_ovf=0.
- Unsigned saturation: 255×255 → out_product=0xFE01, out_result=0xFF, out_ovf=1.
- MULFX_SIGNED_EN, signed:
  - −3×5 → out_product=0xFFF1, out_result=0xF1, ovf=0.
  - −128×−128 → out_product=0x4000, out_result=0x7F, ovf=1.
- FRAC_BITS=4:
  - 0x18×0x18 → product 0x0240, result 0x24.
  - 0x19×0x19 with in_round=1 → product 0x0271, result 0x27.
  - 0x19×0x19 with in_round=0 → result also 0x27.
- Backpressure and back-to-back, BPC=2:
  - Hold out_ready=0 for 5 cycles → outputs stable and in_ready=0.
  - Then assert out_ready with in_valid → new op accepted the same cycle, next result 4 cycles later.
- Reset abort: deassert rst_n at RUN cycle 3 → out_valid never asserts, in_ready=1 the cycle after reset is released, the next op computes correctly.
